// File: rtl/hyperbus_pkg.sv
// rtl/hyperbus_pkg.sv - state encoding and command-address helpers shared by hyperbus_ctrl
package hyperbus_pkg;

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_CA      = 6'b000010,
        S_LAT     = 6'b000100,
        S_WDATA   = 6'b001000,
        S_RDATA   = 6'b010000,
        S_RECOVER = 6'b100000
    } hb_state_t;

    localparam int CA_RW_BIT    = 47;
    localparam int CA_AS_BIT    = 46;
    localparam int CA_BURST_BIT = 45;
    localparam int CA_ROW_MSB   = 44;
    localparam int CA_ROW_LSB   = 16;
    localparam int CA_COL_MSB   = 2;

    localparam logic CMD_READ  = 1'b1;
    localparam logic CMD_WRITE = 1'b0;

    // Row/upper address in CA[44:16], word-within-half-page in CA[2:0].
    function automatic logic [47:0] ca_build(input logic rw, input logic [31:0] adr);
        logic [47:0] ca;
        ca                        = '0;
        ca[CA_RW_BIT]             = rw;
        ca[CA_AS_BIT]             = 1'b0;
        ca[CA_BURST_BIT]          = 1'b1;
        ca[CA_ROW_MSB:CA_ROW_LSB] = adr[31:3];
        ca[CA_COL_MSB:0]          = adr[2:0];
        return ca;
    endfunction

endpackage

// File: rtl/hyperbus_ctrl.sv
// rtl/hyperbus_ctrl.sv - native memory interface to HyperBus PHY transaction controller
module hyperbus_ctrl
    import hyperbus_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 6,
    parameter int CSHI       = 2,
    parameter int RD_TIMEOUT = 64
) (
    input  logic                  hbus_clk,
    input  logic                  hbus_rst,
    input  logic [ADDR_WIDTH-1:0] hbus_adr_i,
    input  logic [DATA_WIDTH-1:0] hbus_dat_i,
    output logic [DATA_WIDTH-1:0] hbus_dat_o,
    input  logic                  hbus_rrq,
    input  logic                  hbus_wrq,
    output logic                  hbus_ready,
    output logic                  hbus_valid,
    output logic                  hbus_busy,
    output logic                  hbus_err,
    output logic                  phy_cs_n,
    output logic                  phy_ck_en,
    output logic [DATA_WIDTH-1:0] phy_dq_o,
    output logic                  phy_dq_oe,
    output logic [1:0]            phy_rwds_o,
    output logic                  phy_rwds_oe,
    input  logic                  phy_rwds_i,
    input  logic [DATA_WIDTH-1:0] phy_dq_i,
    input  logic                  phy_dq_valid
);

    localparam int LAT_W = $clog2(2*LATENCY+1);
    localparam int TO_W  = $clog2(RD_TIMEOUT+1);

    hb_state_t             r_state, w_state;
    logic [LAT_W-1:0]      r_cnt, w_cnt;
    logic [TO_W-1:0]       r_tcnt, w_tcnt;
    logic [31:0]           r_ca, w_ca;
    logic                  r_rd, w_rd;
    logic                  r_dbl, w_dbl;
    logic                  r_cs_n, w_cs_n;
    logic                  r_ck_en, w_ck_en;
    logic                  r_busy, w_busy;
    logic [DATA_WIDTH-1:0] r_dq_o, w_dq_o;
    logic                  r_dq_oe, w_dq_oe;
    logic [1:0]            r_rwds_o, w_rwds_o;
    logic                  r_rwds_oe, w_rwds_oe;
    logic                  r_ready, w_ready;
    logic                  r_valid, w_valid;
    logic                  r_err, w_err;
    logic [DATA_WIDTH-1:0] r_dat_o, w_dat_o;
    logic                  w_consume, w_to_rec;
    logic [LAT_W-1:0]      w_lat;
    logic [47:0]           w_ca_new;

    assign w_lat    = r_dbl ? LAT_W'(2*LATENCY) : LAT_W'(LATENCY);
    assign w_ca_new = ca_build(hbus_rrq ? CMD_READ : CMD_WRITE, 32'(hbus_adr_i));

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_tcnt    = r_tcnt;
        w_ca      = r_ca;
        w_rd      = r_rd;
        w_dbl     = r_dbl;
        w_cs_n    = r_cs_n;
        w_ck_en   = r_ck_en;
        w_busy    = r_busy;
        w_dq_o    = r_dq_o;
        w_dq_oe   = r_dq_oe;
        w_rwds_o  = 2'b00;
        w_rwds_oe = 1'b0;
        w_ready   = r_ready;
        w_valid   = 1'b0;
        w_err     = 1'b0;
        w_dat_o   = r_dat_o;
        w_consume = 1'b0;
        w_to_rec  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if ((hbus_rrq || hbus_wrq) && !r_busy) begin
                    w_state = S_CA;
                    w_ca    = w_ca_new[31:0];
                    w_rd    = hbus_rrq ? CMD_READ : CMD_WRITE;
                    w_cnt   = '0;
                    w_busy  = 1'b1;
                    w_cs_n  = 1'b0;
                    w_ck_en = 1'b1;
                    w_dq_o  = w_ca_new[47:32];
                    w_dq_oe = 1'b1;
                end
            end
            S_CA: begin
                w_cnt = r_cnt + LAT_W'(1);
                if (r_cnt == LAT_W'(0)) begin
                    w_dbl  = phy_rwds_i;
                    w_dq_o = r_ca[31:16];
                end else if (r_cnt == LAT_W'(1)) begin
                    w_dq_o = r_ca[15:0];
                end else begin
                    w_dq_o  = '0;
                    w_dq_oe = 1'b0;
                    w_cnt   = LAT_W'(1);
                    if (r_rd == CMD_READ) begin
                        w_state = S_RDATA;
                        w_tcnt  = '0;
                    end else begin
                        w_state = S_LAT;
                        w_ready = hbus_wrq && (w_lat == LAT_W'(1));
                    end
                end
            end
            S_LAT: begin
                // ready is raised one cycle early so the first word is taken on the LAT->WDATA edge
                if (r_cnt == w_lat) begin
                    if (r_ready && hbus_wrq) begin
                        w_consume = 1'b1;
                        w_state   = S_WDATA;
                    end else if (r_ready) begin
                        w_to_rec = 1'b1;
                    end else begin
                        w_state = S_WDATA;
                        w_ready = 1'b1;
                    end
                end else begin
                    w_cnt   = r_cnt + LAT_W'(1);
                    w_ready = hbus_wrq && ((r_cnt + LAT_W'(1)) == w_lat);
                end
            end
            S_WDATA: begin
                if (hbus_wrq) w_consume = 1'b1;
                else          w_to_rec  = 1'b1;
            end
            S_RDATA: begin
                if (phy_dq_valid) begin
                    if (hbus_rrq) begin
                        w_dat_o = phy_dq_i;
                        w_valid = 1'b1;
                        w_tcnt  = '0;
                    end else begin
                        w_to_rec = 1'b1;
                    end
                end else if (r_tcnt == TO_W'(RD_TIMEOUT-1)) begin
                    w_err    = 1'b1;
                    w_tcnt   = TO_W'(RD_TIMEOUT);
                    w_to_rec = 1'b1;
                end else begin
                    w_tcnt = r_tcnt + TO_W'(1);
                end
            end
            S_RECOVER: begin
                if (r_cnt >= LAT_W'(CSHI)) begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + LAT_W'(1);
                end
            end
            default: w_to_rec = 1'b1;
        endcase

        if (w_consume) begin
            w_dq_o    = hbus_dat_i;
            w_dq_oe   = 1'b1;
            w_rwds_oe = 1'b1;
            w_rwds_o  = 2'b00;
        end
        if (w_to_rec) begin
            w_state   = S_RECOVER;
            w_cnt     = LAT_W'(1);
            w_cs_n    = 1'b1;
            w_ck_en   = 1'b0;
            w_dq_o    = '0;
            w_dq_oe   = 1'b0;
            w_rwds_oe = 1'b0;
            w_ready   = 1'b0;
        end
    end

    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tcnt    <= '0;
            r_ca      <= '0;
            r_rd      <= 1'b0;
            r_dbl     <= 1'b0;
            r_cs_n    <= 1'b1;
            r_ck_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_dq_o    <= '0;
            r_dq_oe   <= 1'b0;
            r_rwds_o  <= 2'b00;
            r_rwds_oe <= 1'b0;
            r_ready   <= 1'b0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_dat_o   <= '0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_tcnt    <= w_tcnt;
            r_ca      <= w_ca;
            r_rd      <= w_rd;
            r_dbl     <= w_dbl;
            r_cs_n    <= w_cs_n;
            r_ck_en   <= w_ck_en;
            r_busy    <= w_busy;
            r_dq_o    <= w_dq_o;
            r_dq_oe   <= w_dq_oe;
            r_rwds_o  <= w_rwds_o;
            r_rwds_oe <= w_rwds_oe;
            r_ready   <= w_ready;
            r_valid   <= w_valid;
            r_err     <= w_err;
            r_dat_o   <= w_dat_o;
        end
    end

    assign hbus_dat_o  = r_dat_o;
    assign hbus_ready  = r_ready;
    assign hbus_valid  = r_valid;
    assign hbus_busy   = r_busy;
    assign hbus_err    = r_err;
    assign phy_cs_n    = r_cs_n;
    assign phy_ck_en   = r_ck_en;
    assign phy_dq_o    = r_dq_o;
    assign phy_dq_oe   = r_dq_oe;
    assign phy_rwds_o  = r_rwds_o;
    assign phy_rwds_oe = r_rwds_oe;

endmodule
